obi_bus_arbiter: RTL and testbench

//  Shares one OBI device port between two hosts: host 0 = instruction fetch, host 1 = memory stage.

---
 rtl/obi_bus_arbiter_if.sv | 43 ++++
 rtl/obi_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_obi_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_bus_arbiter_if.sv
// Bundle of host-side and device-side OBI signals around obi_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding
// hosts plus device seen as one block.
interface obi_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned BE_W = DATA_W / 8;

    // Host side, host n in slice n
    logic [1:0]          h_req_i;
    logic [1:0]          h_gnt_o;
    logic [2*ADDR_W-1:0] h_addr_i;
    logic [1:0]          h_we_i;
    logic [2*BE_W-1:0]   h_be_i;
    logic [2*DATA_W-1:0] h_wdata_i;
    logic [1:0]          h_rvalid_o;
    logic [DATA_W-1:0]   h_rdata_o;

    // Device side
    logic                d_req_o;
    logic                d_gnt_i;
    logic [ADDR_W-1:0]   d_addr_o;
    logic                d_we_o;
    logic [BE_W-1:0]     d_be_o;
    logic [DATA_W-1:0]   d_wdata_o;
    logic                d_rvalid_i;
    logic [DATA_W-1:0]   d_rdata_i;

    modport slave (
        input  h_req_i, h_addr_i, h_we_i, h_be_i, h_wdata_i,
        input  d_gnt_i, d_rvalid_i, d_rdata_i,
        output h_gnt_o, h_rvalid_o, h_rdata_o,
        output d_req_o, d_addr_o, d_we_o, d_be_o, d_wdata_o
    );

    modport master (
        output h_req_i, h_addr_i, h_we_i, h_be_i, h_wdata_i,
        output d_gnt_i, d_rvalid_i, d_rdata_i,
        input  h_gnt_o, h_rvalid_o, h_rdata_o,
        input  d_req_o, d_addr_o, d_we_o, d_be_o, d_wdata_o
    );
endinterface

// File: rtl/obi_bus_arbiter.sv
// Two-host OBI arbiter: host 0 = instruction fetch, host 1 = memory stage.
// One address phase is granted at a time; owners of outstanding transactions are kept
// in an in-order ID FIFO so responses route back combinationally.
// Build option: define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise
// host 1 has fixed priority over host 0.
module obi_bus_arbiter #(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    obi_bus_arbiter_if.slave    bus,
    output logic                err_o
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    // ID FIFO of owner bits, lock and error state
    logic [MAX_OUTSTANDING-1:0] id_q;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       lock_q, lock_d;
    logic                       lock_id_q, lock_id_d;
    logic                       err_q, err_d;

    logic fifo_full, fifo_empty;
    logic winner, sel;
    logic d_req, push, pop, spurious, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_empty = (cnt_q == '0);

`ifdef OBI_ARB_ROUND_ROBIN_EN
    // rr_q names the host that wins the next contention (the one not granted last)
    logic rr_q, rr_d;

    // Round-robin winner among the current requests
    always_comb begin
        winner = rr_q;
        unique case (bus.h_req_i)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = rr_q;
        endcase
    end

    // Pointer moves to the other host on every handshake
    always_comb begin
        rr_d = push ? ~sel : rr_q;
    end

    // Round-robin pointer register, host 1 favoured out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: host 1 whenever it requests, else host 0
    always_comb begin
        winner = bus.h_req_i[1];
    end
`endif

    // Selection, device request and per-host grant
    always_comb begin
        sel   = lock_q ? lock_id_q : winner;
        // A full FIFO blocks the request outright, so rvalid never reaches d_req_o
        d_req = ~rst_i & bus.h_req_i[sel] & ~fifo_full;
        push  = d_req & bus.d_gnt_i;
        bus.d_req_o    = d_req;
        bus.h_gnt_o[0] = push & ~sel;
        bus.h_gnt_o[1] = push & sel;
        bus.d_addr_o   = sel ? bus.h_addr_i[ADDR_W +: ADDR_W]  : bus.h_addr_i[0 +: ADDR_W];
        bus.d_we_o     = sel ? bus.h_we_i[1]                   : bus.h_we_i[0];
        bus.d_be_o     = sel ? bus.h_be_i[BE_W +: BE_W]        : bus.h_be_i[0 +: BE_W];
        bus.d_wdata_o  = sel ? bus.h_wdata_i[DATA_W +: DATA_W] : bus.h_wdata_i[0 +: DATA_W];
    end

    // Response routing to the FIFO head owner; a response with nothing outstanding is dropped
    always_comb begin
        head     = id_q[rd_ptr_q];
        pop      = bus.d_rvalid_i & ~fifo_empty;
        spurious = bus.d_rvalid_i & fifo_empty;
        bus.h_rvalid_o[0] = pop & ~head;
        bus.h_rvalid_o[1] = pop & head;
        bus.h_rdata_o     = bus.d_rdata_i;
        err_o             = err_q;
    end

    // Next-state for FIFO pointers/count, lock and sticky error
    always_comb begin
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d     = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        // An ungranted request pins its host until it is accepted
        if (d_req) begin
            lock_d    = ~bus.d_gnt_i;
            lock_id_d = sel;
        end
        err_d     = err_q | spurious;
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    // Owner storage, written at the tail on each handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q <= '0;
        end else if (push) begin
            id_q[wr_ptr_q] <= sel;
        end
    end
endmodule

// File: tb/tb_obi_bus_arbiter.sv
// Self-checking bench for obi_bus_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based model of the arbitration and response ordering.
module tb_obi_bus_arbiter;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = DW / 8;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst;
    logic err;

    always #5 clk = ~clk;

    obi_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    obi_bus_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .err_o(err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: owners of outstanding transactions in issue order, the host holding
    // an unaccepted request (-1 if none), the host granted last, and the sticky error.
    int owners[$];
    int pend;
    int last;
    bit m_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_sel();
        if (pend >= 0) return pend;
        if (bus.h_req_i == 2'b11) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
            return 1 - last;
`else
            return 1;
`endif
        end
        if (bus.h_req_i[1]) return 1;
        if (bus.h_req_i[0]) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        owners.delete();
        pend  = -1;
        last  = 0;
        m_err = 1'b0;
    endtask

    task automatic rand_payload(input int h);
        bus.h_addr_i[h*AW +: AW]  = {$urandom, $urandom};
        bus.h_we_i[h]             = 1'($urandom_range(0, 1));
        bus.h_be_i[h*BW +: BW]    = 8'($urandom);
        bus.h_wdata_i[h*DW +: DW] = {$urandom, $urandom};
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv);
        bus.h_req_i    = req;
        bus.d_gnt_i    = gnt;
        bus.d_rvalid_i = rv;
        bus.d_rdata_i  = {$urandom, $urandom};
    endtask

    // Called just after a falling edge with inputs applied; checks, clocks, updates model
    task automatic cycle();
        int sel;
        bit dreq;
        bit hs;
        logic [1:0] eg;
        logic [1:0] erv;
        #1;
        sel  = model_sel();
        dreq = 1'b0;
        if (sel >= 0) dreq = bus.h_req_i[sel] && (owners.size() < MO);
        hs   = dreq && bus.d_gnt_i;
        eg   = 2'b00;
        if (hs) eg[sel] = 1'b1;
        erv  = 2'b00;
        if (bus.d_rvalid_i && owners.size() > 0) erv[owners[0]] = 1'b1;
        chk("d_req", 128'(bus.d_req_o), 128'(dreq));
        chk("h_gnt", 128'(bus.h_gnt_o), 128'(eg));
        chk("h_rvalid", 128'(bus.h_rvalid_o), 128'(erv));
        chk("h_rdata", 128'(bus.h_rdata_o), 128'(bus.d_rdata_i));
        chk("err", 128'(err), 128'(m_err));
        if (dreq) begin
            chk("d_addr", 128'(bus.d_addr_o), 128'(bus.h_addr_i[sel*AW +: AW]));
            chk("d_we", 128'(bus.d_we_o), 128'(bus.h_we_i[sel]));
            chk("d_be", 128'(bus.d_be_o), 128'(bus.h_be_i[sel*BW +: BW]));
            chk("d_wdata", 128'(bus.d_wdata_o), 128'(bus.h_wdata_i[sel*DW +: DW]));
        end
        @(posedge clk);
        if (bus.d_rvalid_i) begin
            if (owners.size() > 0) void'(owners.pop_front());
            else m_err = 1'b1;
        end
        if (hs) begin
            owners.push_back(sel);
            pend = -1;
            last = sel;
        end else if (dreq) begin
            pend = sel;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b11, 1'b1, 1'b0);
        #1;
        chk("rst_gnt", 128'(bus.h_gnt_o), 128'(2'b00));
        chk("rst_req", 128'(bus.d_req_o), 128'(1'b0));
        chk("rst_err", 128'(err), 128'(1'b0));
        @(posedge clk);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [1:0] exp_g;
        model_reset();
        rand_payload(0);
        rand_payload(1);
        do_reset();

        // T1: single fetch grant, response next cycle
        drive(2'b01, 1'b1, 1'b0);
        #1 chk("t1_gnt", 128'(bus.h_gnt_o), 128'(2'b01));
        cycle();
        drive(2'b00, 1'b0, 1'b1);
        #1 chk("t1_rvalid", 128'(bus.h_rvalid_o), 128'(2'b01));
        cycle();

        // T2: contention with device stalling; address phase of host 1 held stable
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, (i == 3), 1'b0);
            #1 chk("t2_addr", 128'(bus.d_addr_o), 128'(bus.h_addr_i[AW +: AW]));
            chk("t2_gnt", 128'(bus.h_gnt_o), (i == 3) ? 128'(2'b10) : 128'(2'b00));
            cycle();
        end
        drive(2'b00, 1'b0, 1'b1);
        cycle();

        // T3: FIFO full blocks requests, even in a cycle with a response
        drive(2'b01, 1'b1, 1'b0);
        cycle();
        cycle();
        #1 chk("t3_full_req", 128'(bus.d_req_o), 128'(1'b0));
        cycle();
        drive(2'b01, 1'b1, 1'b1);
        #1 chk("t3_pop_req", 128'(bus.d_req_o), 128'(1'b0));
        chk("t3_rvalid", 128'(bus.h_rvalid_o), 128'(2'b01));
        cycle();
        drive(2'b01, 1'b1, 1'b0);
        #1 chk("t3_req_again", 128'(bus.d_req_o), 128'(1'b1));
        cycle();
        drive(2'b00, 1'b0, 1'b1);
        cycle();
        cycle();

        // T4: in-order routing with a simultaneous push and pop
        drive(2'b01, 1'b1, 1'b0);
        cycle();
        drive(2'b10, 1'b1, 1'b1);
        #1 chk("t4_rvalid0", 128'(bus.h_rvalid_o), 128'(2'b01));
        chk("t4_gnt1", 128'(bus.h_gnt_o), 128'(2'b10));
        cycle();
        drive(2'b00, 1'b0, 1'b1);
        #1 chk("t4_rvalid1", 128'(bus.h_rvalid_o), 128'(2'b10));
        cycle();
        drive(2'b01, 1'b1, 1'b0);
        cycle();
        cycle();
        #1 chk("t4_full", 128'(bus.d_req_o), 128'(1'b0));
        cycle();
        drive(2'b00, 1'b0, 1'b1);
        cycle();
        cycle();

        // T5: response arriving after a mid-transaction reset is spurious and sticky
        drive(2'b01, 1'b1, 1'b0);
        cycle();
        do_reset();
        drive(2'b00, 1'b0, 1'b1);
        #1 chk("t5_rvalid", 128'(bus.h_rvalid_o), 128'(2'b00));
        cycle();
        drive(2'b00, 1'b0, 1'b0);
        #1 chk("t5_err", 128'(err), 128'(1'b1));
        cycle();
        cycle();
        drive(2'b00, 1'b0, 1'b1);
        cycle();
        do_reset();
        #1 chk("t5_err_clr", 128'(err), 128'(1'b0));

        // T6: sustained contention with full-rate device
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 1'b1, (i != 0));
`ifdef OBI_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b10;
`endif
            #1 chk("t6_gnt", 128'(bus.h_gnt_o), 128'(exp_g));
            cycle();
        end
        drive(2'b00, 1'b0, 1'b1);
        cycle();

        // Random traffic obeying OBI: a stalled request keeps its payload until granted
        for (int n = 0; n < 400; n++) begin
            for (int h = 0; h < 2; h++) begin
                if (pend != h) begin
                    bus.h_req_i[h] = 1'($urandom_range(0, 1));
                    rand_payload(h);
                end
            end
            bus.d_gnt_i    = ($urandom_range(0, 9) < 7);
            bus.d_rvalid_i = (owners.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.d_rdata_i  = {$urandom, $urandom};
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
